// File: rtl/mcycle_if.sv
// Handshake bundle between the T-state machine (master) and the machine-cycle
// sequencer (slave): opcode, end-of-cycle strobe, and the cycle qualifiers.
interface mcycle_if #(
    parameter int DATASIZE = 8
);
    logic [DATASIZE-1:0] code;
    logic                mc_end;
    logic                intr;
    logic [2:0]          stat;
    logic [1:0]          mcnt;
    logic                fmc;
    logic                lmc;
    logic                go6;
    logic                bimc;
    logic                halt;
    logic                inta;

    modport master (
        output code, mc_end, intr,
        input  stat, mcnt, fmc, lmc, go6, bimc, halt, inta
    );

    modport slave (
        input  code, mc_end, intr,
        output stat, mcnt, fmc, lmc, go6, bimc, halt, inta
    );
endinterface

// File: rtl/mcycle_ctrl.sv
// 8085 machine-cycle sequencer: decodes the opcode into the M2..M4 bus-cycle list
// and steps through it on mc_end. Define MCYCLE_INTA_EN for the interrupt-acknowledge path.
module mcycle_ctrl (
    input  logic     clk,
    input  logic     rst,
    mcycle_if.slave  bus
);

    typedef enum logic [2:0] {CY_MR, CY_MW, CY_IOR, CY_IOW, CY_BI} cyc_e;
    typedef enum logic [1:0] {ST_M1, ST_MX, ST_HALT} state_e;

    typedef struct packed {
        logic [1:0] len;
        cyc_e       c1;
        cyc_e       c2;
        cyc_e       c3;
    } seq_t;

    typedef struct packed {
        logic go6;
        logic hlt;
        seq_t seq;
    } dec_t;

    function automatic dec_t decode(input logic [7:0] op);
        dec_t d;
        d = '{go6: 1'b0, hlt: 1'b0, seq: '{len: 2'd0, c1: CY_MR, c2: CY_MR, c3: CY_MR}};
        // 76h is tested first, so the ddd/sss != 110 exclusions below hold implicitly
        if (op == 8'h76) begin
            d.hlt = 1'b1;
        end else if (op[7:6] == 2'b00 && op[2:0] == 3'b110 && op[5:3] != 3'b110) begin
            d.seq.len = 2'd1;
        end else if (op[7:6] == 2'b01 && op[2:0] == 3'b110) begin
            d.seq.len = 2'd1;
        end else if (op[7:3] == 5'b01110) begin
            d.seq.len = 2'd1;
            d.seq.c1  = CY_MW;
        end else if (op[7:6] == 2'b00 && op[3:0] == 4'b0001) begin
            d.seq.len = 2'd2;
        end else if (op[7:6] == 2'b00 && op[3:0] == 4'b1001) begin
            d.seq.len = 2'd2;
            d.seq.c1  = CY_BI;
            d.seq.c2  = CY_BI;
        end else if ((op[7:6] == 2'b00 && op[2:0] == 3'b011) || op == 8'hF9 || op == 8'hE9) begin
            d.go6 = 1'b1;
        end else begin
            case (op)
                8'hC3: d.seq.len = 2'd2;
                8'h3A: d.seq.len = 2'd3;
                8'h32: begin d.seq.len = 2'd3; d.seq.c3 = CY_MW;  end
                8'hDB: begin d.seq.len = 2'd2; d.seq.c2 = CY_IOR; end
                8'hD3: begin d.seq.len = 2'd2; d.seq.c2 = CY_IOW; end
                default: ;
            endcase
        end
        return d;
    endfunction

    function automatic logic [2:0] cyc_stat(input cyc_e c);
        case (c)
            CY_MW:   return 3'b001;
            CY_IOR:  return 3'b110;
            CY_IOW:  return 3'b101;
            default: return 3'b010;
        endcase
    endfunction

    logic intr_en;
`ifdef MCYCLE_INTA_EN
    assign intr_en = bus.intr;
`else
    logic unused_intr;
    assign unused_intr = bus.intr;
    assign intr_en     = 1'b0;
`endif

    state_e     state_q, state_d;
    logic [1:0] mcnt_q, mcnt_d;
    seq_t       seq_q, seq_d;
    logic       inta_q, inta_d;
    dec_t       dec;
    cyc_e       cur_cyc;
    logic       lmc_c, go6_c;

    assign dec     = decode(bus.code[7:0]);
    assign cur_cyc = (mcnt_q == 2'd1) ? seq_q.c1 : (mcnt_q == 2'd2) ? seq_q.c2 : seq_q.c3;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        state_d = state_q;
        mcnt_d  = mcnt_q;
        seq_d   = seq_q;
        inta_d  = inta_q;
        lmc_c   = 1'b0;
        go6_c   = 1'b0;
        case (state_q)
            ST_M1: begin
                lmc_c = (dec.seq.len == 2'd0);
                go6_c = dec.go6;
                if (bus.mc_end) begin
                    seq_d  = dec.seq;
                    inta_d = 1'b0;
                    mcnt_d = 2'd0;
                    if (dec.hlt) begin
                        state_d = ST_HALT;
                    end else if (dec.seq.len == 2'd0) begin
                        inta_d = intr_en;
                    end else begin
                        state_d = ST_MX;
                        mcnt_d  = 2'd1;
                    end
                end
            end
            ST_MX: begin
                lmc_c = (mcnt_q == seq_q.len);
                if (bus.mc_end) begin
                    if (lmc_c) begin
                        state_d = ST_M1;
                        mcnt_d  = 2'd0;
                        inta_d  = intr_en;
                    end else begin
                        mcnt_d  = mcnt_q + 2'd1;
                    end
                end
            end
            ST_HALT: begin
                // mc_end is ignored here; only an interrupt can leave without reset
                lmc_c = (dec.seq.len == 2'd0);
                go6_c = dec.go6;
                if (intr_en) begin
                    state_d = ST_M1;
                    inta_d  = 1'b1;
                end
            end
            default: state_d = ST_M1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_M1;
            mcnt_q  <= 2'd0;
            seq_q   <= '{len: 2'd0, c1: CY_MR, c2: CY_MR, c3: CY_MR};
            inta_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mcnt_q  <= mcnt_d;
            seq_q   <= seq_d;
            inta_q  <= inta_d;
        end
    end

    assign bus.stat = (state_q == ST_MX) ? cyc_stat(cur_cyc) : (inta_q ? 3'b111 : 3'b011);
    assign bus.mcnt = mcnt_q;
    assign bus.fmc  = (state_q != ST_MX);
    assign bus.bimc = (state_q == ST_MX) && (cur_cyc == CY_BI);
    assign bus.halt = (state_q == ST_HALT);
    assign bus.inta = inta_q;
    assign bus.lmc  = lmc_c;
    assign bus.go6  = go6_c;

endmodule

// File: tb/tb_mcycle_ctrl.sv
// Self-checking bench for mcycle_ctrl: an opcode table built from the instruction
// classes predicts every machine cycle's stat/mcnt/qualifiers.
module tb_mcycle_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;

    mcycle_if #(.DATASIZE(8)) bus ();

    mcycle_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: per-opcode cycle list after M1
    int       m_len  [256];
    logic [2:0] m_stat [256][3];
    logic     m_bi   [256][3];
    logic     m_go6  [256];

    localparam logic [10:0] RESET_VEC = {3'b011, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam logic [10:0] HALT_VEC  = {3'b011, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    function automatic void put(input int op, input string seq);
        m_len[op] = seq.len();
        for (int i = 0; i < seq.len(); i++) begin
            m_bi[op][i] = 1'b0;
            case (seq.getc(i))
                "R":     m_stat[op][i] = 3'b010;
                "W":     m_stat[op][i] = 3'b001;
                "I":     m_stat[op][i] = 3'b110;
                "O":     m_stat[op][i] = 3'b101;
                default: begin m_stat[op][i] = 3'b010; m_bi[op][i] = 1'b1; end
            endcase
        end
    endfunction

    function automatic void init_model();
        for (int op = 0; op < 256; op++) begin
            m_len[op] = 0;
            m_go6[op] = 1'b0;
        end
        for (int r = 0; r < 8; r++) begin
            if (r != 6) begin
                put(8'h06 | (r << 3), "R");
                put(8'h46 | (r << 3), "R");
                put(8'h70 | r, "W");
            end
        end
        for (int rp = 0; rp < 4; rp++) begin
            put(8'h01 | (rp << 4), "RR");
            put(8'h09 | (rp << 4), "BB");
            m_go6[8'h03 | (rp << 4)] = 1'b1;
            m_go6[8'h0B | (rp << 4)] = 1'b1;
        end
        put(8'hC3, "RR");
        put(8'h3A, "RRR");
        put(8'h32, "RRW");
        put(8'hDB, "RI");
        put(8'hD3, "RO");
        m_go6[8'hF9] = 1'b1;
        m_go6[8'hE9] = 1'b1;
    endfunction

    function automatic logic [10:0] obs();
        return {bus.stat, bus.mcnt, bus.fmc, bus.lmc, bus.go6, bus.bimc, bus.halt, bus.inta};
    endfunction

    // Drives one whole instruction, with 'gap' idle clocks before each mc_end
    task automatic run_instr(input logic [7:0] op, input int gap, input string tag);
        logic [10:0] e;
        logic [10:0] o;
        for (int k = 0; k <= m_len[op]; k++) begin
            if (k == 0)
                e = {3'b011, 2'd0, 1'b1, m_len[op] == 0, m_go6[op], 3'b000};
            else
                e = {m_stat[op][k-1], 2'(k), 1'b0, k == m_len[op], 1'b0, m_bi[op][k-1], 2'b00};
            for (int g = 0; g <= gap; g++) begin
                @(negedge clk);
                bus.code   = (k == 0) ? op : 8'($urandom);
                bus.mc_end = (g == gap);
                #1;
                o = obs();
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL %s op=%02h m%0d: got %b expected %b", tag, op, k, o, e);
                end
            end
        end
    endtask

    task automatic test_reset();
        logic [10:0] o;
        bus.code = 8'h00; bus.mc_end = 1'b0; bus.intr = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1; o = obs(); checks++;
        if (o !== RESET_VEC) begin errors++; $display("FAIL reset_held: got %b expected %b", o, RESET_VEC); end
        @(negedge clk);
        rst = 1'b0;
        #1; o = obs(); checks++;
        if (o !== RESET_VEC) begin errors++; $display("FAIL reset_release: got %b expected %b", o, RESET_VEC); end
    endtask

    task automatic test_directed();
        run_instr(8'h3A, 0, "lda");
        run_instr(8'hD3, 1, "out");
        run_instr(8'h23, 0, "inx");
        run_instr(8'h09, 2, "dad");
        run_instr(8'h32, 0, "sta");
        run_instr(8'h77, 1, "movmr");
        run_instr(8'h00, 0, "nop");
    endtask

    task automatic test_back_to_back();
        logic [7:0] op;
        for (int i = 0; i < 25; i++) begin
            op = 8'($urandom);
            if (op == 8'h76) op = 8'h3A;
            run_instr(op, 0, "b2b");
        end
    endtask

    task automatic test_random();
        logic [7:0] op;
        for (int i = 0; i < 80; i++) begin
            op = 8'($urandom_range(0, 255));
            if (op == 8'h76) op = 8'hDB;
            run_instr(op, int'($urandom_range(0, 2)), "rand");
        end
    endtask

    task automatic test_halt();
        logic [10:0] o;
        logic [10:0] e;
        @(negedge clk);
        bus.code = 8'h76; bus.mc_end = 1'b1; bus.intr = 1'b0;
        #1; o = obs(); e = {3'b011, 2'd0, 1'b1, 1'b1, 1'b0, 3'b000}; checks++;
        if (o !== e) begin errors++; $display("FAIL hlt_m1: got %b expected %b", o, e); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.code = 8'h00; bus.mc_end = 1'b1;
            #1; o = obs(); checks++;
            if (o !== HALT_VEC) begin errors++; $display("FAIL halt_hold%0d: got %b expected %b", i, o, HALT_VEC); end
        end
        @(negedge clk);
        bus.mc_end = 1'b0; bus.intr = 1'b1;
        #1; o = obs(); checks++;
        if (o !== HALT_VEC) begin errors++; $display("FAIL halt_intr_setup: got %b expected %b", o, HALT_VEC); end
        @(negedge clk);
        bus.intr = 1'b0;
`ifdef MCYCLE_INTA_EN
        e = {3'b111, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
`else
        e = HALT_VEC;
`endif
        #1; o = obs(); checks++;
        if (o !== e) begin errors++; $display("FAIL halt_intr: got %b expected %b", o, e); end
        @(negedge clk);
        bus.mc_end = 1'b1;
        #1; o = obs(); checks++;
        if (o !== e) begin errors++; $display("FAIL inta_cycle: got %b expected %b", o, e); end
        @(negedge clk);
        bus.mc_end = 1'b0;
`ifdef MCYCLE_INTA_EN
        e = RESET_VEC;
`endif
        #1; o = obs(); checks++;
        if (o !== e) begin errors++; $display("FAIL after_inta: got %b expected %b", o, e); end
        #2 rst = 1'b1;
        #1; o = obs(); checks++;
        if (o !== RESET_VEC) begin errors++; $display("FAIL halt_rst: got %b expected %b", o, RESET_VEC); end
        @(negedge clk);
        rst = 1'b0;
        run_instr(8'hDB, 0, "post_halt");
    endtask

    task automatic test_rst_mid();
        logic [10:0] o;
        logic [10:0] e;
        @(negedge clk);
        bus.code = 8'h3A; bus.mc_end = 1'b1;
        @(negedge clk);
        bus.code = 8'($urandom); bus.mc_end = 1'b1;
        @(negedge clk);
        bus.mc_end = 1'b0;
        #1; o = obs(); e = {3'b010, 2'd2, 1'b0, 1'b0, 1'b0, 3'b000}; checks++;
        if (o !== e) begin errors++; $display("FAIL lda_m3: got %b expected %b", o, e); end
        #2;
        bus.code = 8'h00;
        rst = 1'b1;
        #1; o = obs(); checks++;
        if (o !== RESET_VEC) begin errors++; $display("FAIL rst_mid: got %b expected %b", o, RESET_VEC); end
        @(negedge clk);
        rst = 1'b0;
        run_instr(8'hD3, 0, "post_rst_out");
        run_instr(8'h09, 0, "post_rst_dad");
    endtask

    initial begin
        init_model();
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_halt();
        test_rst_mid();
        @(negedge clk);
        bus.mc_end = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mcycle_ctrl.md
# mcycle_ctrl

Machine-cycle sequencer for the 8085 core. It sits beside the T-state machine and tells it which machine cycle (M1..M4) is running, the bus-cycle type and status pins, and the fmc/lmc/go6/bimc/halt qualifiers it branches on. The sequence is decoded from the opcode in the Instruction Register and advanced by the T-state machine's end-of-cycle strobe.

## Interface
- DATASIZE, 8, opcode width
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- code  in  DATASIZE  opcode from Instruction Register; valid from T3 of M1 until mc_end of M1
- mc_end  in  1  one-clk pulse on the last T-state of each machine cycle
- intr  in  1  interrupt request; used only with MCYCLE_INTA_EN
- stat  out  3  {IO/M_, S1, S0} of the current cycle
- mcnt  out  2  index of the current machine cycle (0 = M1)
- fmc  out  1  current cycle is M1
- lmc  out  1  current cycle is the last of the instruction
- go6  out  1  M1 is a 6-T opcode fetch
- bimc  out  1  current cycle is bus-idle
- halt  out  1  HLT executed
- inta  out  1  current M1 is an interrupt-acknowledge cycle (0 without macro)

## Operation
- Cycle types and stat encoding:
  - OF = 011
  - MR = 010
  - MW = 001
  - IOR = 110
  - IOW = 101
  - INTA = 111
  - BI = 010, with bimc=1
- M1 is always OF, or INTA (see Configuration).
- Opcode decode gives the sequence after M1:
  - MVI r (00ddd110, ddd≠110): MR
  - MOV r,M (01ddd110, ddd≠110): MR
  - MOV M,r (01110sss, sss≠110): MW
  - LXI (00rr0001): MR,MR
  - JMP C3: MR,MR
  - LDA 3A: MR,MR,MR
  - STA 32: MR,MR,MW
  - IN DB: MR,IOR
  - OUT D3: MR,IOW
  - DAD (00rr1001): BI,BI
  - HLT 76: none, and sets halt
  - INX/DCX (00rr0011/00rr1011), SPHL F9, PCHL E9: none, with go6=1
  - all other opcodes: none, 4-T OF
- On mc_end in M1: code is latched into the sequence register, and mcnt advances or returns to 0.
- On any later mc_end: mcnt advances; stat and bimc come from the latched sequence. A code change after M1 has no effect.
- On mc_end of the last cycle: mcnt=0, stat=OF, fmc=1.
- lmc:
  - during M1, combinational from code: 1 if the decoded sequence is empty
  - otherwise (mcnt == length)
- go6: combinational from code during M1; 0 in all other cycles.
- halt:
  - set by mc_end of an M1 decoding 76
  - while halt=1, mc_end is ignored and stat holds OF
  - cleared only by rst, or by the interrupt path under the macro

## Timing
- stat, mcnt, fmc, bimc, halt and inta are registered; they change only on a clk edge where mc_end=1, or on rst.
- lmc and go6 are combinational from code and internal state, with zero latency. The T-state machine samples them in T3/T4 of M1.
- Sequence latency: each mc_end advances exactly one machine cycle; there are no bubbles.
- Reset (asynchronous, immediate): stat=011, mcnt=0, fmc=1, bimc=0, halt=0, inta=0. lmc and go6 follow the decode of code (code=00h gives lmc=1, go6=0).
- rst mid-instruction: the sequence is abandoned and all outputs go to their reset values at once.
- A continuous mc_end (asserted every clk) is legal; one cycle advances per clk.

## Configuration
- MCYCLE_INTA_EN defined:
  - On mc_end of the last cycle of an instruction, or on any clk while halt=1: if intr=1, the next M1 is INTA. Then stat=111, inta=1, fmc=1, and halt clears.
  - code read at INTA is decoded like an OF opcode; inta clears on that cycle's mc_end.
- Not defined: intr is ignored, inta is tied 0, and halt clears only on rst.

## Test plan
- Reset with code=00h -> stat=011, mcnt=0, fmc=1, lmc=1, go6=0, bimc=0, halt=0.
- code=3A plus 4 mc_end pulses -> stat 011,010,010,010; mcnt 0,1,2,3; lmc=1 only at mcnt=3; after the 4th pulse, stat=011 and fmc=1.
- code=D3 -> stat 011,010,101. code=23 -> go6=1 and lmc=1 in M1, next cycle is M1 again.
- code=09 -> stat 011,010,010 with bimc 0,1,1; lmc=1 at mcnt=2.
- code=76 then mc_end -> halt=1, and further mc_end leaves stat/mcnt unchanged. With MCYCLE_INTA_EN: intr=1 -> stat=111, inta=1, halt=0. Without it: intr ignored.
- rst pulse during mcnt=2 of LDA -> immediately stat=011, mcnt=0, fmc=1; the next sequence decodes normally.
